// File: rtl/riscv_cache_biu_ctrl.sv
// Cache-to-BIU burst engine: moves one cache block per command as a single
// incrementing burst (READWAY = line fill, WRITEWAY = dirty-way writeback).
module riscv_cache_biu_ctrl #(
    parameter  int XLEN       = 32,
    parameter  int PLEN       = 32,
    parameter  int BLOCK_SIZE = 32,
    localparam int BLK_BITS   = BLOCK_SIZE * 8,
    localparam int BURST_SIZE = BLK_BITS / XLEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          biucmd_i,
    input  logic [PLEN-1:0]     biucmd_adri_i,
    input  logic [BLK_BITS-1:0] biucmd_d_i,
    output logic [BLK_BITS-1:0] biucmd_q_o,
    output logic                biucmd_ack_o,
    output logic                biucmd_err_o,
    output logic                biucmd_busy_o,
    output logic                biu_stb_o,
    input  logic                biu_stb_ack_i,
    input  logic                biu_d_ack_i,
    output logic [PLEN-1:0]     biu_adri_o,
    output logic [2:0]          biu_size_o,
    output logic [2:0]          biu_type_o,
    output logic                biu_we_o,
    output logic [XLEN-1:0]     biu_d_o,
    input  logic [XLEN-1:0]     biu_q_i,
    input  logic                biu_ack_i,
    input  logic                biu_err_i
);

    typedef enum logic [1:0] {
        BIUCMD_NOP      = 2'd0,
        BIUCMD_READWAY  = 2'd1,
        BIUCMD_WRITEWAY = 2'd2
    } biucmd_t;

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    localparam int       CW    = $clog2(BURST_SIZE) + 1;
    localparam logic [2:0] BSIZE = 3'($clog2(XLEN / 8));
    localparam logic [2:0] BTYPE = (BURST_SIZE == 16) ? 3'd7 :
                                   (BURST_SIZE == 8)  ? 3'd5 :
                                   (BURST_SIZE == 4)  ? 3'd3 :
                                   (BURST_SIZE == 1)  ? 3'd0 : 3'd1;

    state_t              state;
    logic [CW-1:0]       dcnt, acnt;
    logic [BLK_BITS-1:0] wblk;
    logic                cnt_en, beat, last, dbeat;

    // Beats only count once the request has been accepted; in the stb_ack
    // cycle itself the slave may already be returning the first beat.
    assign cnt_en = (state == REQ && biu_stb_ack_i) || state == XFER;
    assign beat   = cnt_en & biu_ack_i & ~biu_err_i;
    assign last   = beat && (acnt == CW'(BURST_SIZE - 1));
    assign dbeat  = cnt_en & biu_we_o & biu_d_ack_i & (dcnt != CW'(BURST_SIZE));

    assign biucmd_busy_o = (state != IDLE);

    // Write beat follows dcnt; once all beats are consumed the last one is held.
    always_comb begin
        biu_d_o = wblk[(BURST_SIZE-1)*XLEN +: XLEN];
        for (int n = 0; n < BURST_SIZE; n++)
            if (dcnt == CW'(n)) biu_d_o = wblk[n*XLEN +: XLEN];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            dcnt         <= '0;
            acnt         <= '0;
            wblk         <= '0;
            biucmd_q_o   <= '0;
            biucmd_ack_o <= 1'b0;
            biucmd_err_o <= 1'b0;
            biu_stb_o    <= 1'b0;
            biu_we_o     <= 1'b0;
            biu_adri_o   <= '0;
            biu_size_o   <= '0;
            biu_type_o   <= '0;
        end else begin
            biucmd_ack_o <= 1'b0;
            biucmd_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (biucmd_i == BIUCMD_READWAY || biucmd_i == BIUCMD_WRITEWAY) begin
                        state      <= REQ;
                        biu_stb_o  <= 1'b1;
                        biu_we_o   <= (biucmd_i == BIUCMD_WRITEWAY);
                        biu_adri_o <= biucmd_adri_i & ~PLEN'(BLOCK_SIZE - 1);
                        biu_size_o <= BSIZE;
                        biu_type_o <= BTYPE;
                        dcnt       <= '0;
                        acnt       <= '0;
                        if (biucmd_i == BIUCMD_WRITEWAY) wblk <= biucmd_d_i;
                    end
                end
                REQ, XFER: begin
                    if (cnt_en) begin
                        biu_stb_o <= 1'b0;
                        if (biu_err_i) begin
                            biucmd_err_o <= 1'b1;
                            biu_we_o     <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            if (dbeat) dcnt <= dcnt + 1'b1;
                            if (beat) begin
                                acnt <= acnt + 1'b1;
                                if (!biu_we_o)
                                    for (int n = 0; n < BURST_SIZE; n++)
                                        if (acnt == CW'(n)) biucmd_q_o[n*XLEN +: XLEN] <= biu_q_i;
                            end
                            if (last) begin
                                state        <= DONE;
                                biu_we_o     <= 1'b0;
                                biucmd_ack_o <= 1'b1;
                            end else begin
                                state <= XFER;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
